dspl_scan: RTL and testbench

Parametrised multiplexed seven-segment scan driver that generalises the fixed 8-digit display path to 1..8 digits, with a configurable refresh rate, tear-free frame loading, leading-zero suppression, per-digit enable and decimal point. It sits between the data producers (Fibonacci, Timer, mode/prog status) and the board's common-anode display pins (`an`, `dec_cat`). Producers write a whole frame with a one-cycle `load` strobe. The block applies the frame only at a scan-frame boundary and acknowledges it.

---
 rtl/dspl_scan.sv | 189 ++++++++++++++++++
 tb/tb_dspl_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dspl_scan.sv
// Multiplexed seven-segment scan driver: 1..8 digits, frame-boundary loading,
// leading-zero suppression, per-digit enable/dp. Optional blink: DSPL_SCAN_BLINK_EN.
module dspl_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   en,
  input  logic                    lz_supp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              dec_cat,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TC_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tc;
  logic [IW-1:0]           idx;
  logic                    tc_term;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_en;

  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   blink_off;
  logic                    run;

  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;

  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      4'hF: s = 8'h71;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign tc_term = (tc == TC_LAST);
  assign wrap    = tc_term && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc  <= '0;
      idx <= '0;
    end else if (tc_term) begin
      tc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      tc  <= tc + TW'(1);
    end
  end

  // A load landing on the wrap edge only fills the shadow; the wrap itself
  // applies whatever shadow was already pending before that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      pending    <= 1'b0;
      act_digits <= '0;
      act_dp     <= '0;
      act_en     <= '0;
    end else begin
      if (load) begin
        sh_digits <= digits;
        sh_dp     <= dp;
        sh_en     <= en;
      end
      if (wrap && pending) begin
        act_digits <= sh_digits;
        act_dp     <= sh_dp;
        act_en     <= sh_en;
      end
      pending <= load | (pending & ~wrap);
    end
  end

`ifdef DSPL_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] fcnt;
  logic          blink_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (wrap) begin
      if (fcnt == BF_LAST) begin
        fcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + BW'(1);
      end
    end
  end

  assign blink_off = blink_on ? '0 : blink_mask;
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES > 1);
  assign blink_off    = '0;
`endif

  // Disabled digits are transparent to suppression: only enabled higher digits gate it.
  always_comb begin
    run  = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (act_en[i]) begin
        run = run & (act_digits[4*i +: 4] == 4'h0) & ~act_dp[i];
      end
      supp[i] = run & lz_supp;
    end
  end

  always_comb begin
    sel       = '0;
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = ~act_en[i] | supp[i] | blink_off[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= '1;
      dec_cat    <= 8'hFF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      load_ack   <= wrap & pending;
      if (cur_blank) begin
        an      <= '1;
        dec_cat <= 8'hFF;
      end else begin
        an      <= ~sel;
        dec_cat <= seg7(cur_nib) & ~{7'b0, cur_dp};
      end
    end
  end

endmodule

// File: tb/tb_dspl_scan.sv
// Directed self-checking bench for dspl_scan (4 digits, 4 cycles per digit).
module tb_dspl_scan;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  digits = '0;
  logic [3:0]   dp = '0;
  logic [3:0]   en = '0;
  logic         lz_supp = 1'b0;
  logic [3:0]   blink_mask = '0;
  logic [3:0]   an;
  logic [7:0]   dec_cat;
  logic         load_ack;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dspl_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .dp(dp), .en(en),
    .lz_supp(lz_supp), .blink_mask(blink_mask), .an(an), .dec_cat(dec_cat),
    .load_ack(load_ack), .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances to the next frame_done sample; bounded.
  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
  endtask

  task automatic load_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    digits = d;
    dp     = p;
    en     = e;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit lit;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: an=%b required 1111", an); end
    checks++; if (dec_cat !== 8'hFF) begin errors++; $display("FAIL reset_cat: dec_cat=%h required ff", dec_cat); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: load_ack=%b required 0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: frame_done=%b required 0", frame_done); end
    rst = 1'b1;
    lit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (an !== 4'hF || dec_cat !== 8'hFF) lit = 1'b1;
    end
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL dark_after_reset: lit=%b required 0", lit); end
    wait_frame();
    n = 0;
    do begin tick(); n++; end while (frame_done !== 1'b1 && n < 40);
    checks++; if (n != 16) begin errors++; $display("FAIL frame_period: %0d cycles required 16", n); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_width: frame_done=%b required 0", frame_done); end
  endtask

  task automatic test_load();
    logic [3:0] ea [4];
    logic [7:0] ec [4];
    int  n;
    int  d;
    bit  early;
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ec = '{8'h71, 8'h25, 8'h10, 8'h9F};
    wait_frame();
    repeat (5) tick();
    load_frame(16'h1A2F, 4'b0100, 4'hF);
    n = 0;
    early = 1'b0;
    do begin
      tick();
      n++;
      if (frame_done !== 1'b1 && (load_ack !== 1'b0 || an !== 4'hF)) early = 1'b1;
    end while (frame_done !== 1'b1 && n < 40);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL load_early: change before wrap=%b required 0", early); end
    checks++; if (n != 10) begin errors++; $display("FAIL load_wrap_pos: wrap after %0d cycles required 10", n); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL load_ack: load_ack=%b required 1 with frame_done", load_ack); end
    for (int j = 1; j <= 16; j++) begin
      tick();
      d = (j - 1) / 4;
      if (j == 1) begin
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL ack_width: load_ack=%b required 0", load_ack); end
      end
      checks++; if (an !== ea[d]) begin errors++; $display("FAIL load_an[%0d]: an=%b required %b", j, an, ea[d]); end
      checks++; if (dec_cat !== ec[d]) begin errors++; $display("FAIL load_cat[%0d]: dec_cat=%h required %h", j, dec_cat, ec[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [4];
    int acks;
    int d;
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame();
    repeat (2) tick();
    load_frame(16'h1111, 4'b0000, 4'hF);
    repeat (3) tick();
    load_frame(16'h2222, 4'b0000, 4'hF);
    acks = 0;
    for (int j = 0; j < 9; j++) begin
      tick();
      if (load_ack === 1'b1) acks++;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_align: frame_done=%b required 1", frame_done); end
    for (int j = 1; j <= 16; j++) begin
      tick();
      d = (j - 1) / 4;
      if (load_ack === 1'b1) acks++;
      checks++; if (an !== ea[d]) begin errors++; $display("FAIL b2b_an[%0d]: an=%b required %b", j, an, ea[d]); end
      checks++; if (dec_cat !== 8'h25) begin errors++; $display("FAIL b2b_cat[%0d]: dec_cat=%h required 25", j, dec_cat); end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL b2b_acks: %0d acks required 1", acks); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_align2: frame_done=%b required 1", frame_done); end
    repeat (15) tick();
    load_frame(16'h3333, 4'b0000, 4'hF);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrapload_fd: frame_done=%b required 1", frame_done); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL wrapload_noack: load_ack=%b required 0", load_ack); end
    tick();
    checks++; if (dec_cat !== 8'h25) begin errors++; $display("FAIL wrapload_old: dec_cat=%h required 25", dec_cat); end
    wait_frame();
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL wrapload_ack: load_ack=%b required 1", load_ack); end
    for (int j = 1; j <= 16; j++) begin
      tick();
      d = (j - 1) / 4;
      checks++; if (an !== ea[d]) begin errors++; $display("FAIL wrapload_an[%0d]: an=%b required %b", j, an, ea[d]); end
      checks++; if (dec_cat !== 8'h0D) begin errors++; $display("FAIL wrapload_cat[%0d]: dec_cat=%h required 0d", j, dec_cat); end
    end
  endtask

  task automatic test_lz_supp();
    logic [15:0] td [4];
    logic [3:0]  tp [4];
    logic [3:0]  te [4];
    logic [3:0]  ea [4][4];
    logic [7:0]  ec [4][4];
    int d;
    td = '{16'h0030, 16'h0000, 16'h0000, 16'h0305};
    tp = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    te = '{4'b1111, 4'b1111, 4'b1111, 4'b1011};
    ea = '{'{4'b1110, 4'b1101, 4'b1111, 4'b1111},
           '{4'b1110, 4'b1111, 4'b1111, 4'b1111},
           '{4'b1110, 4'b1101, 4'b1011, 4'b1111},
           '{4'b1110, 4'b1111, 4'b1111, 4'b1111}};
    ec = '{'{8'h03, 8'h0D, 8'hFF, 8'hFF},
           '{8'h03, 8'hFF, 8'hFF, 8'hFF},
           '{8'h03, 8'h03, 8'h02, 8'hFF},
           '{8'h49, 8'hFF, 8'hFF, 8'hFF}};
    lz_supp = 1'b1;
    for (int v = 0; v < 4; v++) begin
      wait_frame();
      load_frame(td[v], tp[v], te[v]);
      wait_frame();
      checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL lz_ack[%0d]: load_ack=%b required 1", v, load_ack); end
      for (int j = 1; j <= 16; j++) begin
        tick();
        d = (j - 1) / 4;
        checks++; if (an !== ea[v][d]) begin errors++; $display("FAIL lz_an[%0d][%0d]: an=%b required %b", v, j, an, ea[v][d]); end
        checks++; if (dec_cat !== ec[v][d]) begin errors++; $display("FAIL lz_cat[%0d][%0d]: dec_cat=%h required %h", v, j, dec_cat, ec[v][d]); end
      end
    end
    lz_supp = 1'b0;
  endtask

  task automatic test_reset_pending();
    bit bad_ack;
    bit lit;
    repeat (2) tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rstp_pre: an=%b required 1110", an); end
    load_frame(16'h8888, 4'b0000, 4'hF);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rstp_an: an=%b required 1111", an); end
    checks++; if (dec_cat !== 8'hFF) begin errors++; $display("FAIL rstp_cat: dec_cat=%h required ff", dec_cat); end
    tick();
    rst = 1'b1;
    bad_ack = 1'b0;
    lit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load_ack !== 1'b0) bad_ack = 1'b1;
      if (an !== 4'hF) lit = 1'b1;
    end
    checks++; if (bad_ack !== 1'b0) begin errors++; $display("FAIL rstp_noack: ack seen=%b required 0", bad_ack); end
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL rstp_blank: lit=%b required 0", lit); end
  endtask

  task automatic test_blink();
    bit dark;
    logic [3:0] xa;
    logic [7:0] xc;
    blink_mask = 4'b0001;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_frame(16'h0008, 4'b0000, 4'b0001);
    wait_frame();
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL blink_ack: load_ack=%b required 1", load_ack); end
    for (int f = 1; f <= 7; f++) begin
`ifdef DSPL_SCAN_BLINK_EN
      dark = (f == 2 || f == 3 || f == 6 || f == 7);
`else
      dark = 1'b0;
`endif
      xa = dark ? 4'b1111 : 4'b1110;
      xc = dark ? 8'hFF : 8'h01;
      for (int j = 1; j <= 4; j++) begin
        tick();
        checks++; if (an !== xa) begin errors++; $display("FAIL blink_an[f%0d]: an=%b required %b", f, an, xa); end
        checks++; if (dec_cat !== xc) begin errors++; $display("FAIL blink_cat[f%0d]: dec_cat=%h required %h", f, dec_cat, xc); end
      end
      wait_frame();
    end
    blink_mask = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_lz_supp();
    test_reset_pending();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
